// File: rtl/mux_21_rr_arb_if.sv
// Handshake bundle between two packet sources, the round-robin arbiter and
// the downstream consumer of the merged stream.
interface mux_21_rr_arb_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] in_0;
    logic             in_0_valid;
    logic             in_0_last;
    logic             in_0_ready;
    logic [WIDTH-1:0] in_1;
    logic             in_1_valid;
    logic             in_1_last;
    logic             in_1_ready;
    logic [WIDTH-1:0] mux_out;
    logic             mux_out_valid;
    logic             mux_out_last;
    logic             mux_out_ready;
    logic             sel;

    // Environment side: drives the sources and the downstream ready.
    modport master (
        output in_0, in_0_valid, in_0_last,
        output in_1, in_1_valid, in_1_last,
        output mux_out_ready,
        input  in_0_ready, in_1_ready,
        input  mux_out, mux_out_valid, mux_out_last, sel
    );

    // Arbiter side.
    modport slave (
        input  in_0, in_0_valid, in_0_last,
        input  in_1, in_1_valid, in_1_last,
        input  mux_out_ready,
        output in_0_ready, in_1_ready,
        output mux_out, mux_out_valid, mux_out_last, sel
    );
endinterface

// File: rtl/mux_21_rr_arb.sv
// Two-input round-robin packet arbiter with a one-entry registered output
// stage. A grant is held for a whole packet; priority flips after each packet.
module mux_21_rr_arb #(
    parameter int unsigned WIDTH = 8
) (
    input logic              clk,
    input logic              rst_n,
    mux_21_rr_arb_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             prio_q, prio_d;
    logic [WIDTH-1:0] mux_out_q, mux_out_d;
    logic             mux_out_valid_q, mux_out_valid_d;
    logic             mux_out_last_q, mux_out_last_d;
    logic             sel_q, sel_d;

    logic             out_free;
    logic             rdy_0, rdy_1;
    logic             xfer_0, xfer_1;

    // Ready depends only on grant state and output-stage occupancy.
    always_comb begin
        out_free = !mux_out_valid_q || bus.mux_out_ready;
        rdy_0    = (state_q == LOCK0) && out_free;
        rdy_1    = (state_q == LOCK1) && out_free;
        xfer_0   = bus.in_0_valid && rdy_0;
        xfer_1   = bus.in_1_valid && rdy_1;
    end

    // Next-state: arbitration, packet lock and output register loading.
    always_comb begin
        state_d         = state_q;
        prio_d          = prio_q;
        mux_out_d       = mux_out_q;
        mux_out_valid_d = mux_out_valid_q;
        mux_out_last_d  = mux_out_last_q;
        sel_d           = sel_q;

        case (state_q)
            IDLE: begin
                if (bus.in_0_valid && (!bus.in_1_valid || !prio_q)) begin
                    state_d = LOCK0;
                end else if (bus.in_1_valid) begin
                    state_d = LOCK1;
                end
            end
            LOCK0: begin
                if (xfer_0 && bus.in_0_last) begin
                    state_d = IDLE;
                    prio_d  = 1'b1;
                end
            end
            LOCK1: begin
                if (xfer_1 && bus.in_1_last) begin
                    state_d = IDLE;
                    prio_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (xfer_0) begin
            mux_out_d       = bus.in_0;
            mux_out_last_d  = bus.in_0_last;
            sel_d           = 1'b0;
            mux_out_valid_d = 1'b1;
        end else if (xfer_1) begin
            mux_out_d       = bus.in_1;
            mux_out_last_d  = bus.in_1_last;
            sel_d           = 1'b1;
            mux_out_valid_d = 1'b1;
        end else if (mux_out_valid_q && bus.mux_out_ready) begin
            mux_out_valid_d = 1'b0;
        end
    end

    // State and output registers; reset discards any held beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            prio_q          <= 1'b0;
            mux_out_q       <= '0;
            mux_out_valid_q <= 1'b0;
            mux_out_last_q  <= 1'b0;
            sel_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            prio_q          <= prio_d;
            mux_out_q       <= mux_out_d;
            mux_out_valid_q <= mux_out_valid_d;
            mux_out_last_q  <= mux_out_last_d;
            sel_q           <= sel_d;
        end
    end

    assign bus.in_0_ready    = rdy_0;
    assign bus.in_1_ready    = rdy_1;
    assign bus.mux_out       = mux_out_q;
    assign bus.mux_out_valid = mux_out_valid_q;
    assign bus.mux_out_last  = mux_out_last_q;
    assign bus.sel           = sel_q;
endmodule

// File: tb/tb_mux_21_rr_arb.sv
// Directed bench for the round-robin packet arbiter.
module tb_mux_21_rr_arb;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    mux_21_rr_arb_if #(.WIDTH(8)) bus ();

    mux_21_rr_arb #(.WIDTH(8)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [7:0] d,
                           input logic s, input logic l);
        chk({tag, ".valid"}, {31'd0, bus.mux_out_valid}, {31'd0, v});
        chk({tag, ".data"},  {24'd0, bus.mux_out},       {24'd0, d});
        chk({tag, ".sel"},   {31'd0, bus.sel},           {31'd0, s});
        chk({tag, ".last"},  {31'd0, bus.mux_out_last},  {31'd0, l});
    endtask

    task automatic chk_rdy(input string tag, input logic r0, input logic r1);
        #1;
        chk({tag, ".rdy0"}, {31'd0, bus.in_0_ready}, {31'd0, r0});
        chk({tag, ".rdy1"}, {31'd0, bus.in_1_ready}, {31'd0, r1});
    endtask

    task automatic src0(input logic v, input logic [7:0] d, input logic l);
        bus.in_0_valid = v;
        bus.in_0       = d;
        bus.in_0_last  = l;
    endtask

    task automatic src1(input logic v, input logic [7:0] d, input logic l);
        bus.in_1_valid = v;
        bus.in_1       = d;
        bus.in_1_last  = l;
    endtask

    // Holds reset for two edges; caller sets source inputs before release.
    task automatic hold_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
    endtask

    logic       exp_v [9];
    logic [7:0] exp_d [9];
    logic       exp_s [9];
    logic       exp_l [9];
    logic       f0, f1;
    logic       a, b;

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.mux_out_ready = 1'b1;
        src0(1'b1, 8'hC0, 1'b1);
        src1(1'b1, 8'hD0, 1'b1);

        // ---- reset with both sources requesting ----
        cyc();
        cyc();
        chk_out("rst", 1'b0, 8'h00, 1'b0, 1'b0);
        chk_rdy("rst", 1'b0, 1'b0);
        rst_n = 1'b1;
        cyc();
        chk_rdy("rel.e1", 1'b1, 1'b0);
        chk_out("rel.e1", 1'b0, 8'h00, 1'b0, 1'b0);
        cyc();
        chk_out("rel.e2", 1'b1, 8'hC0, 1'b0, 1'b1);
        chk_rdy("rel.e2", 1'b0, 1'b0);

        // ---- fairness: continuous 2-beat packets from both ----
        hold_reset();
        a = 1'b0;
        b = 1'b0;
        src0(1'b1, 8'hA0, 1'b0);
        src1(1'b1, 8'hB0, 1'b0);
        rst_n = 1'b1;
        exp_v = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        exp_d = '{8'h00, 8'hA0, 8'hA1, 8'hA1, 8'hB0, 8'hB1, 8'hB1, 8'hA0, 8'hA1};
        exp_s = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        exp_l = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 9; k++) begin
            #2;
            f0 = bus.in_0_valid && bus.in_0_ready;
            f1 = bus.in_1_valid && bus.in_1_ready;
            cyc();
            if (f0) a = ~a;
            if (f1) b = ~b;
            src0(1'b1, 8'hA0 + {7'd0, a}, a);
            src1(1'b1, 8'hB0 + {7'd0, b}, b);
            chk($sformatf("fair.e%0d.valid", k + 1), {31'd0, bus.mux_out_valid}, {31'd0, exp_v[k]});
            if (exp_v[k]) begin
                chk($sformatf("fair.e%0d.data", k + 1), {24'd0, bus.mux_out}, {24'd0, exp_d[k]});
                chk($sformatf("fair.e%0d.sel", k + 1), {31'd0, bus.sel}, {31'd0, exp_s[k]});
                chk($sformatf("fair.e%0d.last", k + 1), {31'd0, bus.mux_out_last}, {31'd0, exp_l[k]});
            end
        end

        // ---- lock hold: in_0 stalls mid-packet, in_1 waits ----
        hold_reset();
        src0(1'b1, 8'h11, 1'b0);
        src1(1'b1, 8'h21, 1'b1);
        rst_n = 1'b1;
        cyc();
        chk_rdy("lock.e1", 1'b1, 1'b0);
        cyc();
        chk_out("lock.e2", 1'b1, 8'h11, 1'b0, 1'b0);
        src0(1'b0, 8'h11, 1'b0);
        chk_rdy("lock.e2", 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk_rdy($sformatf("lock.gap%0d", k), 1'b1, 1'b0);
        end
        src0(1'b1, 8'h12, 1'b1);
        cyc();
        chk_out("lock.e6", 1'b1, 8'h12, 1'b0, 1'b1);
        src0(1'b0, 8'h00, 1'b0);
        chk_rdy("lock.e6", 1'b0, 1'b0);
        cyc();
        chk_rdy("lock.e7", 1'b0, 1'b1);
        cyc();
        chk_out("lock.e8", 1'b1, 8'h21, 1'b1, 1'b1);

        // ---- backpressure with 0x33 held ----
        hold_reset();
        src0(1'b1, 8'h33, 1'b0);
        src1(1'b1, 8'h44, 1'b1);
        rst_n = 1'b1;
        cyc();
        cyc();
        chk_out("bp.load", 1'b1, 8'h33, 1'b0, 1'b0);
        src0(1'b1, 8'h34, 1'b1);
        bus.mux_out_ready = 1'b0;
        chk_rdy("bp.stall0", 1'b0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            cyc();
            chk_out($sformatf("bp.hold%0d", k), 1'b1, 8'h33, 1'b0, 1'b0);
            chk_rdy($sformatf("bp.hold%0d", k), 1'b0, 1'b0);
        end
        bus.mux_out_ready = 1'b1;
        chk_rdy("bp.resume", 1'b1, 1'b0);
        cyc();
        chk_out("bp.next", 1'b1, 8'h34, 1'b0, 1'b1);

        // ---- lone requester on in_1 with prio 0 ----
        hold_reset();
        src0(1'b0, 8'h00, 1'b0);
        src1(1'b1, 8'h55, 1'b1);
        rst_n = 1'b1;
        cyc();
        chk_rdy("lone.e1", 1'b0, 1'b1);
        cyc();
        chk_out("lone.e2", 1'b1, 8'h55, 1'b1, 1'b1);

        // ---- reset in the middle of a 3-beat in_1 packet ----
        hold_reset();
        src1(1'b1, 8'h61, 1'b0);
        rst_n = 1'b1;
        cyc();
        cyc();
        chk_out("mid.b1", 1'b1, 8'h61, 1'b1, 1'b0);
        src1(1'b1, 8'h62, 1'b0);
        cyc();
        chk_out("mid.b2", 1'b1, 8'h62, 1'b1, 1'b0);
        src1(1'b1, 8'h63, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_out("mid.rst", 1'b0, 8'h00, 1'b0, 1'b0);
        chk_rdy("mid.rst", 1'b0, 1'b0);
        src0(1'b1, 8'h71, 1'b1);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk_rdy("mid.arb", 1'b1, 1'b0);
        cyc();
        chk_out("mid.first", 1'b1, 8'h71, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
